// File: rtl/host_status_pkg.sv
`default_nettype none
// ============================================================================
// Module      : host_status_pkg
// Description : Shared types and constants for the tohost status responder:
//               FSM state encoding, register offsets and STATUS bit indices.
// Revision    : 1.0 - initial release
// ============================================================================
package host_status_pkg;

  // Responder FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    RSTREQ = 2'd2,
    HALT   = 2'd3
  } state_t;

  // Byte offsets inside the 16-byte register window
  localparam logic [3:0] TOHOST_OFS = 4'h0;
  localparam logic [3:0] STATUS_OFS = 4'h4;
  localparam logic [3:0] CYCLE_OFS  = 4'h8;

  // STATUS register bit positions
  localparam int unsigned STATUS_RUN_BIT     = 0;
  localparam int unsigned STATUS_DONE_BIT    = 1;
  localparam int unsigned STATUS_PASS_BIT    = 2;
  localparam int unsigned STATUS_TIMEOUT_BIT = 3;
  localparam int unsigned STATUS_RSTREQ_BIT  = 4;

endpackage : host_status_pkg
`default_nettype wire

// File: rtl/host_status_timer.sv
`default_nettype none
// ============================================================================
// Module      : host_status_timer
// Description : 32-bit saturating run-cycle counter with synchronous clear,
//               count enable and an expiry compare against LIMIT-1.
// Revision    : 1.0 - initial release
// ============================================================================
module host_status_timer #(
  parameter int unsigned LIMIT = 2_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        enable,
  output logic [31:0] count,
  output logic        expired
);

  localparam logic [31:0] C_LAST = 32'(LIMIT - 1);

  // Counter: clear wins over enable; holds at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != 32'hFFFF_FFFF)) begin
      count <= count + 32'd1;
    end
  end

  // Expiry is seen in the last RUN cycle so the edge leaving it sets timeout
  assign expired = (count == C_LAST);

endmodule : host_status_timer
`default_nettype wire

// File: rtl/host_status_responder.sv
`default_nettype none
// ============================================================================
// Module      : host_status_responder
// Description : Memory-mapped riscv-tests tohost responder. Decodes TOHOST
//               writes into pass/fail, runs a timeout, and requests a core
//               reset after a pass. Exposes STATUS and CYCLE registers.
// Revision    : 1.0 - initial release
// ============================================================================
module host_status_responder
  import host_status_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h8000_1000,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
  parameter int unsigned RESET_HOLD     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        test_start,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        done,
  output logic        pass,
  output logic [30:0] fail_testnum,
  output logic        timeout,
  output logic        core_rst_req,
  output logic [31:0] cycle_count
);

  localparam int unsigned        HOLD_W      = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HOLD_W-1:0]  C_HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

  state_t              r_state;
  logic                r_done;
  logic                r_pass;
  logic                r_timeout;
  logic [30:0]         r_fail_testnum;
  logic                r_core_rst_req;
  logic [HOLD_W-1:0]   r_hold;
  logic [31:0]         r_tohost;
  logic                r_resp_valid;
  logic [31:0]         r_resp_rdata;

  logic                w_accept;
  logic                w_hit;
  logic [3:0]          w_ofs;
  logic                w_rd;
  logic                w_tohost_wr;
  logic                w_exit_wr;
  logic                w_start;
  logic                w_run;
  logic                w_expired;
  logic [31:0]         w_count;
  logic [31:0]         w_status;
  logic [31:0]         w_rdata;
  logic                w_unused_addr;

  // The core is held in reset during RSTREQ, so the bus is closed then
  assign req_ready   = (r_state != RSTREQ);
  assign w_accept    = req_valid & req_ready;
  assign w_hit       = (req_addr[31:4] == BASE_ADDR[31:4]);
  assign w_ofs       = {req_addr[3:2], 2'b00};
  assign w_unused_addr = ^req_addr[1:0];
  assign w_rd        = w_accept & w_hit & ~req_we;
  assign w_tohost_wr = w_accept & w_hit & req_we & (w_ofs == TOHOST_OFS) & (req_be == 4'hF);
  // Only odd TOHOST values end a test; even values are syscall requests
  assign w_exit_wr   = w_tohost_wr & req_wdata[0];
  assign w_start     = test_start & (r_state != RSTREQ);
  assign w_run       = (r_state == RUN);

  host_status_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_start),
    .enable  (w_run),
    .count   (w_count),
    .expired (w_expired)
  );

  // STATUS word assembled from the pre-edge flags
  always_comb begin
    w_status                     = '0;
    w_status[STATUS_RUN_BIT]     = w_run;
    w_status[STATUS_DONE_BIT]    = r_done;
    w_status[STATUS_PASS_BIT]    = r_pass;
    w_status[STATUS_TIMEOUT_BIT] = r_timeout;
    w_status[STATUS_RSTREQ_BIT]  = r_core_rst_req;
  end

  // Read mux: misses, writes and the reserved slot all return zero
  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      case (w_ofs)
        TOHOST_OFS: w_rdata = r_tohost;
        STATUS_OFS: w_rdata = w_status;
        CYCLE_OFS:  w_rdata = w_count;
        default:    w_rdata = '0;
      endcase
    end
  end

  // Bus response pipeline and TOHOST storage
  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_tohost     <= '0;
    end else begin
      r_resp_valid <= w_accept;
      r_resp_rdata <= w_rdata;
      if (w_tohost_wr) begin
        r_tohost <= req_wdata;
      end
    end
  end

  // Test-run FSM: start has priority over exit writes, which beat timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_done         <= 1'b0;
      r_pass         <= 1'b0;
      r_timeout      <= 1'b0;
      r_fail_testnum <= '0;
      r_core_rst_req <= 1'b0;
      r_hold         <= '0;
    end else begin
      case (r_state)
        IDLE, HALT: begin
          if (test_start) begin
            r_state        <= RUN;
            r_done         <= 1'b0;
            r_pass         <= 1'b0;
            r_timeout      <= 1'b0;
            r_fail_testnum <= '0;
          end
        end
        RUN: begin
          if (test_start) begin
            r_done         <= 1'b0;
            r_pass         <= 1'b0;
            r_timeout      <= 1'b0;
            r_fail_testnum <= '0;
          end else if (w_exit_wr) begin
            r_done <= 1'b1;
            if (req_wdata == 32'h0000_0001) begin
              r_pass         <= 1'b1;
              r_core_rst_req <= 1'b1;
              r_hold         <= C_HOLD_LAST;
              r_state        <= RSTREQ;
            end else begin
              r_fail_testnum <= req_wdata[31:1];
              r_state        <= HALT;
            end
          end else if (w_expired) begin
            r_timeout <= 1'b1;
            r_state   <= HALT;
          end
        end
        RSTREQ: begin
          if (r_hold == '0) begin
            r_core_rst_req <= 1'b0;
            r_state        <= IDLE;
          end else begin
            r_hold <= r_hold - HOLD_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign resp_valid   = r_resp_valid;
  assign resp_rdata   = r_resp_rdata;
  assign done         = r_done;
  assign pass         = r_pass;
  assign fail_testnum = r_fail_testnum;
  assign timeout      = r_timeout;
  assign core_rst_req = r_core_rst_req;
  assign cycle_count  = w_count;

endmodule : host_status_responder
`default_nettype wire

// File: tb/tb_host_status_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_host_status_responder
// Description : Self-checking bench for host_status_responder. Bus responses
//               are scored against a queue of expected read data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_host_status_responder;

  localparam logic [31:0] BASE = 32'h8000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        test_start = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        done;
  logic        pass;
  logic [30:0] fail_testnum;
  logic        timeout;
  logic        core_rst_req;
  logic [31:0] cycle_count;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  host_status_responder #(
    .BASE_ADDR      (BASE),
    .TIMEOUT_CYCLES (20),
    .RESET_HOLD     (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .test_start   (test_start),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_be       (req_be),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .done         (done),
    .pass         (pass),
    .fail_testnum (fail_testnum),
    .timeout      (timeout),
    .core_rst_req (core_rst_req),
    .cycle_count  (cycle_count)
  );

  always #5 clk = ~clk;

  // Scoreboard: every response pops the oldest expected read value
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: got rdata=%h with nothing outstanding", resp_rdata);
      end else begin
        logic [31:0] exp;
        exp = exp_q.pop_front();
        if (resp_rdata !== exp) begin
          errors++;
          $display("FAIL resp_rdata: got %h expected %h", resp_rdata, exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One bus transfer, optionally with test_start in the same cycle
  task automatic bus_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, input logic [31:0] exp_rdata, input logic start);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    req_be     = be;
    test_start = start;
    exp_q.push_back(exp_rdata);
    tick();
    req_valid  = 1'b0;
    req_we     = 1'b0;
    test_start = 1'b0;
  endtask

  task automatic pulse_start;
    test_start = 1'b1;
    tick();
    test_start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass: got %b expected 0", pass); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
    checks++; if (core_rst_req !== 1'b0) begin errors++; $display("FAIL reset_rstreq: got %b expected 0", core_rst_req); end
    checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL reset_cycle: got %0d expected 0", cycle_count); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_pass;
    int n;
    pulse_start();
    checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL pass_cycle_start: got %0d expected 0", cycle_count); end
    repeat (10) tick();
    checks++; if (cycle_count !== 32'd10) begin errors++; $display("FAIL pass_cycle_10: got %0d expected 10", cycle_count); end
    bus_access(1'b0, BASE + 32'h4, 32'h0, 4'hF, 32'h0000_0001, 1'b0);
    bus_access(1'b1, BASE, 32'h0000_0001, 4'hF, 32'h0, 1'b0);
    checks++; if ({done, pass, core_rst_req, req_ready} !== 4'b1110) begin
      errors++; $display("FAIL pass_flags: got done/pass/rstreq/ready=%b expected 1110", {done, pass, core_rst_req, req_ready});
    end
    n = 0;
    while (core_rst_req === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    checks++; if (n != 4) begin errors++; $display("FAIL pass_rstreq_len: got %0d expected 4", n); end
    checks++; if ({done, pass, req_ready} !== 3'b111) begin
      errors++; $display("FAIL pass_retained: got done/pass/ready=%b expected 111", {done, pass, req_ready});
    end
    bus_access(1'b0, BASE + 32'h4, 32'h0, 4'hF, 32'h0000_0006, 1'b0);
  endtask

  task automatic test_fail;
    pulse_start();
    repeat (3) tick();
    bus_access(1'b0, BASE + 32'h4, 32'h0, 4'hF, 32'h0000_0001, 1'b0);
    bus_access(1'b1, BASE, 32'h0000_0007, 4'hF, 32'h0, 1'b0);
    checks++; if ({done, pass, core_rst_req} !== 3'b100) begin
      errors++; $display("FAIL fail_flags: got done/pass/rstreq=%b expected 100", {done, pass, core_rst_req});
    end
    checks++; if (fail_testnum !== 31'd3) begin errors++; $display("FAIL fail_testnum: got %0d expected 3", fail_testnum); end
    bus_access(1'b0, BASE + 32'h4, 32'h0, 4'hF, 32'h0000_0002, 1'b0);
    bus_access(1'b0, BASE, 32'h0, 4'hF, 32'h0000_0007, 1'b0);
    repeat (30) tick();
    checks++; if ({timeout, done, fail_testnum} !== {2'b01, 31'd3}) begin
      errors++; $display("FAIL fail_halt_hold: got timeout=%b done=%b testnum=%0d expected 0 1 3", timeout, done, fail_testnum);
    end
  endtask

  task automatic test_timeout;
    int n;
    pulse_start();
    n = 0;
    while (timeout !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++; if (n != 20) begin errors++; $display("FAIL timeout_latency: got %0d expected 20", n); end
    checks++; if (cycle_count !== 32'd20) begin errors++; $display("FAIL timeout_cycle: got %0d expected 20", cycle_count); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL timeout_done: got %b expected 0", done); end
    repeat (5) tick();
    checks++; if ({timeout, cycle_count} !== {1'b1, 32'd20}) begin
      errors++; $display("FAIL timeout_hold: got timeout=%b cycle=%0d expected 1 20", timeout, cycle_count);
    end
    // back-to-back reads across the whole window
    bus_access(1'b0, BASE + 32'h4, 32'h0, 4'hF, 32'h0000_0008, 1'b0);
    bus_access(1'b0, BASE + 32'h8, 32'h0, 4'hF, 32'd20, 1'b0);
    bus_access(1'b0, BASE + 32'hC, 32'h0, 4'hF, 32'h0, 1'b0);
    bus_access(1'b0, BASE, 32'h0, 4'hF, 32'h0000_0007, 1'b0);
    pulse_start();
    checks++; if ({timeout, cycle_count} !== {1'b0, 32'd0}) begin
      errors++; $display("FAIL timeout_clear: got timeout=%b cycle=%0d expected 0 0", timeout, cycle_count);
    end
  endtask

  task automatic test_ignored;
    bus_access(1'b1, BASE + 32'h10, 32'h0000_0001, 4'hF, 32'h0, 1'b0);
    bus_access(1'b1, BASE, 32'h0000_0001, 4'h3, 32'h0, 1'b0);
    bus_access(1'b1, BASE, 32'h0000_0002, 4'hF, 32'h0, 1'b0);
    bus_access(1'b1, BASE + 32'h4, 32'h0000_001F, 4'hF, 32'h0, 1'b0);
    checks++; if ({done, pass, timeout, core_rst_req} !== 4'b0000) begin
      errors++; $display("FAIL ignored_flags: got done/pass/timeout/rstreq=%b expected 0000", {done, pass, timeout, core_rst_req});
    end
    bus_access(1'b0, BASE, 32'h0, 4'hF, 32'h0000_0002, 1'b0);
    bus_access(1'b0, BASE + 32'h10, 32'h0, 4'hF, 32'h0, 1'b0);
    // test_start beats an exit write in the same cycle
    bus_access(1'b1, BASE, 32'h0000_0007, 4'hF, 32'h0, 1'b1);
    checks++; if ({done, cycle_count} !== {1'b0, 32'd0}) begin
      errors++; $display("FAIL start_priority: got done=%b cycle=%0d expected 0 0", done, cycle_count);
    end
    bus_access(1'b0, BASE + 32'h4, 32'h0, 4'hF, 32'h0000_0001, 1'b0);
  endtask

  task automatic test_simultaneous;
    int n;
    pulse_start();
    repeat (19) tick();
    checks++; if (cycle_count !== 32'd19) begin errors++; $display("FAIL simul_cycle: got %0d expected 19", cycle_count); end
    bus_access(1'b1, BASE, 32'h0000_0001, 4'hF, 32'h0, 1'b0);
    checks++; if ({done, pass, timeout} !== 3'b110) begin
      errors++; $display("FAIL simul_flags: got done/pass/timeout=%b expected 110", {done, pass, timeout});
    end
    n = 0;
    while (core_rst_req === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    checks++; if (n != 4) begin errors++; $display("FAIL simul_rstreq_len: got %0d expected 4", n); end
  endtask

  task automatic test_rst_mid;
    pulse_start();
    repeat (2) tick();
    bus_access(1'b1, BASE, 32'h0000_0001, 4'hF, 32'h0, 1'b0);
    tick();
    checks++; if ({core_rst_req, req_ready} !== 2'b10) begin
      errors++; $display("FAIL rstmid_pre: got rstreq/ready=%b expected 10", {core_rst_req, req_ready});
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({done, pass, timeout, core_rst_req, resp_valid, req_ready} !== 6'b000001) begin
      errors++; $display("FAIL rstmid_flags: got done/pass/timeout/rstreq/resp/ready=%b expected 000001",
                         {done, pass, timeout, core_rst_req, resp_valid, req_ready});
    end
    checks++; if ({fail_testnum, cycle_count} !== 63'd0) begin
      errors++; $display("FAIL rstmid_values: got testnum=%0d cycle=%0d expected 0 0", fail_testnum, cycle_count);
    end
    bus_access(1'b0, BASE + 32'h4, 32'h0, 4'hF, 32'h0, 1'b0);
    bus_access(1'b0, BASE, 32'h0, 4'hF, 32'h0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_timeout();
    test_ignored();
    test_simultaneous();
    test_rst_mid();
    repeat (3) tick();
    checks++; if (exp_q.size() != 0) begin
      errors++; $display("FAIL resp_missing: got %0d outstanding expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_host_status_responder
`default_nettype wire
